litedram_csr_arbiter: RTL and testbench

// - 2-master Wishbone arbiter sharing the single LiteDRAM control/CSR port (wb_ctrl_*) between the DDR3

---
 rtl/litedram_ctrl_pkg.sv | 30 +++
 rtl/wb_bus_watchdog.sv | 44 ++++
 rtl/litedram_csr_arbiter.sv | 139 +++++++++++++
 tb/tb_litedram_csr_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/litedram_ctrl_pkg.sv
// Shared LiteDRAM control-port definitions: bus widths, DFII CSR map, and arbiter types.
// The init sequencer uses the same DFII constants.
package litedram_ctrl_pkg;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_DATA_W = 32;

    // DFII CSR word addresses on the control bus
    localparam logic [29:0] DFII_CONTROL_ADR       = 30'h0000_1000;
    localparam logic [29:0] DFII_PI0_COMMAND_ADR   = 30'h0000_1004;
    localparam logic [29:0] DFII_PI0_CMD_ISSUE_ADR = 30'h0000_1008;
    localparam logic [29:0] DFII_PI0_ADDRESS_ADR   = 30'h0000_100C;
    localparam logic [29:0] DFII_PI0_BADDRESS_ADR  = 30'h0000_1010;

    localparam int DFII_CONTROL_SEL     = 0;
    localparam int DFII_CONTROL_CKE     = 1;
    localparam int DFII_CONTROL_ODT     = 2;
    localparam int DFII_CONTROL_RESET_N = 3;

    localparam int DFII_COMMAND_CS     = 0;
    localparam int DFII_COMMAND_WE     = 1;
    localparam int DFII_COMMAND_CAS    = 2;
    localparam int DFII_COMMAND_RAS    = 3;
    localparam int DFII_COMMAND_WRDATA = 4;
    localparam int DFII_COMMAND_RDDATA = 5;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT0, ARB_GRANT1} arb_state_t;
    typedef enum logic {MST_M0, MST_M1} master_t;

endpackage

// File: rtl/wb_bus_watchdog.sv
// Aborts a Wishbone strobe that stays unterminated for TIMEOUT_CYCLES and keeps abort statistics.
module wb_bus_watchdog
#(
    parameter int TIMEOUT_CYCLES = 1024
)
(
    input  logic       sys_clk_100mhz,
    input  logic       rst_n,
    input  logic       bus_cyc,
    input  logic       bus_stb,
    input  logic       s_ack,
    input  logic       s_err,
    output logic       wd_err,
    output logic       timeout_flag,
    output logic [7:0] timeout_count
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // A slave termination in the firing cycle suppresses the abort
    assign wd_err = bus_cyc && bus_stb && !s_ack && !s_err && (count == CNT_MAX);

    always_ff @(posedge sys_clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            timeout_flag  <= 1'b0;
            timeout_count <= 8'd0;
        end else begin
            if (!bus_cyc || s_ack || s_err || wd_err)
                count <= '0;
            else if (bus_stb)
                count <= count + 1'b1;

            if (wd_err) begin
                timeout_flag <= 1'b1;
                if (timeout_count != 8'hFF)
                    timeout_count <= timeout_count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/litedram_csr_arbiter.sv
// Two-master Wishbone arbiter for the LiteDRAM CSR port: m0 exclusive until init_done,
// then round-robin with bus lock while cyc stays high.
module litedram_csr_arbiter
    import litedram_ctrl_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int SEL_W         = DATA_W / 8
)
(
    input  logic              sys_clk_100mhz,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_dat_w,
    input  logic [SEL_W-1:0]  m0_sel,
    output logic [DATA_W-1:0] m0_dat_r,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_dat_w,
    input  logic [SEL_W-1:0]  m1_sel,
    output logic [DATA_W-1:0] m1_dat_r,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_adr,
    output logic [DATA_W-1:0] s_dat_w,
    output logic [SEL_W-1:0]  s_sel,
    input  logic [DATA_W-1:0] s_dat_r,
    input  logic              s_ack,
    input  logic              s_err,
    output logic              timeout_flag,
    output logic [7:0]        timeout_count
);
    arb_state_t state, next_state;
    master_t    last_grant;
    logic       req0, req1, bus_cyc, bus_stb, wd_err;

    assign req0     = m0_cyc;
    assign req1     = m1_cyc & init_done;
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    // Derived from state and master inputs directly so the watchdog sees no path through the output mux
    assign bus_cyc = ((state == ARB_GRANT0) && m0_cyc) || ((state == ARB_GRANT1) && m1_cyc);
    assign bus_stb = ((state == ARB_GRANT0) && m0_cyc && m0_stb) ||
                     ((state == ARB_GRANT1) && m1_cyc && m1_stb);

    always_ff @(posedge sys_clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= MST_M1;
        end else begin
            state <= next_state;
            if (state == ARB_IDLE && next_state == ARB_GRANT0)
                last_grant <= MST_M0;
            else if (state == ARB_IDLE && next_state == ARB_GRANT1)
                last_grant <= MST_M1;
        end
    end

    always_comb begin
        next_state = state;
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_adr      = '0;
        s_dat_w    = '0;
        s_sel      = '0;
        unique case (state)
            ARB_IDLE: begin
                if (req0 && (!req1 || last_grant == MST_M1))
                    next_state = ARB_GRANT0;
                else if (req1)
                    next_state = ARB_GRANT1;
            end
            ARB_GRANT0: begin
                s_cyc   = m0_cyc;
                s_stb   = m0_stb;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_w = m0_dat_w;
                s_sel   = m0_sel;
                if (!m0_cyc)
                    next_state = ARB_IDLE;
            end
            ARB_GRANT1: begin
                s_cyc   = m1_cyc;
                s_stb   = m1_stb;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_w = m1_dat_w;
                s_sel   = m1_sel;
                if (!m1_cyc)
                    next_state = ARB_IDLE;
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        m0_ack = 1'b0;
        m0_err = 1'b0;
        m1_ack = 1'b0;
        m1_err = 1'b0;
        if (state == ARB_GRANT0) begin
            m0_ack = s_ack & m0_stb;
            m0_err = (s_err | wd_err) & m0_stb;
        end else if (state == ARB_GRANT1) begin
            m1_ack = s_ack & m1_stb;
            m1_err = (s_err | wd_err) & m1_stb;
        end
    end

    wb_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .sys_clk_100mhz (sys_clk_100mhz),
        .rst_n          (rst_n),
        .bus_cyc        (bus_cyc),
        .bus_stb        (bus_stb),
        .s_ack          (s_ack),
        .s_err          (s_err),
        .wd_err         (wd_err),
        .timeout_flag   (timeout_flag),
        .timeout_count  (timeout_count)
    );

endmodule

// File: tb/tb_litedram_csr_arbiter.sv
// Directed bench for litedram_csr_arbiter: init lockout, round-robin, reads, watchdog and reset.
module tb_litedram_csr_arbiter;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    logic              sys_clk_100mhz = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_done = 1'b0;
    logic              m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [ADDR_W-1:0] m0_adr = '0;
    logic [DATA_W-1:0] m0_dat_w = '0;
    logic [SEL_W-1:0]  m0_sel = '0;
    logic [DATA_W-1:0] m0_dat_r;
    logic              m0_ack, m0_err;
    logic              m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [ADDR_W-1:0] m1_adr = '0;
    logic [DATA_W-1:0] m1_dat_w = '0;
    logic [SEL_W-1:0]  m1_sel = '0;
    logic [DATA_W-1:0] m1_dat_r;
    logic              m1_ack, m1_err;
    logic              s_cyc, s_stb, s_we;
    logic [ADDR_W-1:0] s_adr;
    logic [DATA_W-1:0] s_dat_w;
    logic [SEL_W-1:0]  s_sel;
    logic [DATA_W-1:0] s_dat_r = '0;
    logic              s_ack = 0, s_err = 0;
    logic              timeout_flag;
    logic [7:0]        timeout_count;

    int total = 0;
    int bad = 0;

    always #5 sys_clk_100mhz = ~sys_clk_100mhz;

    litedram_csr_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .sys_clk_100mhz(sys_clk_100mhz), .rst_n(rst_n), .init_done(init_done),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_dat_r(m0_dat_r),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_dat_r(m1_dat_r),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_err(s_err),
        .timeout_flag(timeout_flag), .timeout_count(timeout_count)
    );

    task automatic tick();
        @(posedge sys_clk_100mhz);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge sys_clk_100mhz);
        #1;
        total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL reset_s_cyc got=%b want=0", s_cyc); end
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b want=0", timeout_flag); end
        total++; if (timeout_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", timeout_count); end
        total++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin bad++; $display("FAIL reset_term got=%b want=0000", {m0_ack, m0_err, m1_ack, m1_err}); end
        rst_n = 1'b1;
    endtask

    task automatic test_init_lockout();
        init_done = 1'b0;
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 30'h1000; m0_dat_w = 32'h0E; m0_sel = 4'hF;
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 30'h2000;
        tick();
        total++; if ({s_cyc, s_stb, s_we} !== 3'b111 || s_adr !== 30'h1000 || s_dat_w !== 32'h0E || s_sel !== 4'hF) begin
            bad++; $display("FAIL init_m0_bus got cyc/stb/we=%b adr=%h dat=%h want 111 1000 0000000e", {s_cyc, s_stb, s_we}, s_adr, s_dat_w); end
        s_ack = 1; #1;
        total++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin bad++; $display("FAIL init_ack got m0=%b m1=%b want m0=1 m1=0", m0_ack, m1_ack); end
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        tick();
        repeat (3) tick();
        total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL init_m1_blocked got s_cyc=%b want=0", s_cyc); end
        s_ack = 1; #1;
        total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL idle_spurious_ack got m0=%b m1=%b want 0 0", m0_ack, m1_ack); end
        s_ack = 0;
        m1_cyc = 0; m1_stb = 0;
        tick();
    endtask

    task automatic test_round_robin();
        int winner;
        logic [ADDR_W-1:0] exp_adr;
        pulse_reset();
        init_done = 1'b1;
        m0_adr = 30'h1004; m0_we = 1; m1_adr = 30'h2004; m1_we = 0;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        total++; if (s_adr !== 30'h1004) begin bad++; $display("FAIL rr_first_m0 got adr=%h want=1004", s_adr); end
        s_ack = 1; #1;
        total++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin bad++; $display("FAIL rr_first_ack got m0=%b m1=%b want 1 0", m0_ack, m1_ack); end
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL rr_idle_gap got s_cyc=%b want=0", s_cyc); end
        tick();
        total++; if (s_cyc !== 1'b1 || s_adr !== 30'h2004) begin bad++; $display("FAIL rr_then_m1 got cyc=%b adr=%h want 1 2004", s_cyc, s_adr); end
        m1_cyc = 0; m1_stb = 0;
        tick();
        for (int r = 0; r < 4; r++) begin
            winner  = (r % 2 == 0) ? 0 : 1;
            exp_adr = (winner == 0) ? 30'h1004 : 30'h2004;
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
            tick();
            total++; if (s_adr !== exp_adr) begin bad++; $display("FAIL rr_round%0d got adr=%h want=%h", r, s_adr, exp_adr); end
            s_ack = 1; #1;
            total++; if ({m0_ack, m1_ack} !== ((winner == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL rr_round%0d_ack got m0/m1=%b%b want winner m%0d", r, m0_ack, m1_ack, winner); end
            tick();
            s_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
            tick();
        end
    endtask

    task automatic test_read();
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 30'h100C;
        tick();
        total++; if (s_stb !== 1'b1 || s_we !== 1'b0 || s_adr !== 30'h100C) begin
            bad++; $display("FAIL read_bus got stb=%b we=%b adr=%h want 1 0 100c", s_stb, s_we, s_adr); end
        repeat (3) tick();
        s_ack = 1; s_dat_r = 32'hD70; #1;
        total++; if (m1_dat_r !== 32'hD70 || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
            bad++; $display("FAIL read_data got dat=%h m1_ack=%b m0_ack=%b want 00000d70 1 0", m1_dat_r, m1_ack, m0_ack); end
        tick();
        s_ack = 0; s_dat_r = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL read_release got s_cyc=%b want=0", s_cyc); end
    endtask

    task automatic test_timeout();
        int early = 0;
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 30'h1008;
        tick();
        for (int i = 1; i < 15; i++) begin
            tick();
            if (m0_err !== 1'b0) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL wd_early got err_cycles=%0d want=0", early); end
        tick();
        total++; if (m0_err !== 1'b1 || m1_err !== 1'b0) begin bad++; $display("FAIL wd_fire got m0_err=%b m1_err=%b want 1 0", m0_err, m1_err); end
        tick();
        total++; if (m0_err !== 1'b0) begin bad++; $display("FAIL wd_pulse_width got m0_err=%b want=0", m0_err); end
        total++; if (timeout_flag !== 1'b1 || timeout_count !== 8'd1) begin
            bad++; $display("FAIL wd_stats got flag=%b count=%0d want 1 1", timeout_flag, timeout_count); end
        m0_cyc = 0; m0_stb = 0;
        tick();
    endtask

    task automatic test_ack_beats_timeout();
        m0_cyc = 1; m0_stb = 1;
        tick();
        repeat (15) tick();
        s_ack = 1; #1;
        total++; if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin bad++; $display("FAIL ack_vs_wd got ack=%b err=%b want 1 0", m0_ack, m0_err); end
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        total++; if (timeout_count !== 8'd1) begin bad++; $display("FAIL ack_vs_wd_count got=%0d want=1", timeout_count); end
    endtask

    task automatic test_saturate();
        m0_cyc = 1; m0_stb = 1;
        tick();
        repeat (16 * 10) tick();
        total++; if (timeout_count !== 8'd11) begin bad++; $display("FAIL sat_partial got=%0d want=11", timeout_count); end
        repeat (16 * 290) tick();
        total++; if (timeout_count !== 8'd255) begin bad++; $display("FAIL sat_full got=%0d want=255", timeout_count); end
        m0_cyc = 0; m0_stb = 0;
        tick();
    endtask

    task automatic test_async_reset();
        init_done = 1'b1;
        m1_cyc = 1; m1_stb = 1; m1_adr = 30'h1010;
        tick();
        total++; if (s_cyc !== 1'b1) begin bad++; $display("FAIL areset_pre got s_cyc=%b want=1", s_cyc); end
        #2 rst_n = 1'b0;
        s_ack = 1;
        #1;
        total++; if (s_cyc !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL areset_bus got cyc=%b ack=%b want 0 0", s_cyc, m1_ack); end
        total++; if (timeout_flag !== 1'b0 || timeout_count !== 8'd0) begin
            bad++; $display("FAIL areset_stats got flag=%b count=%0d want 0 0", timeout_flag, timeout_count); end
        s_ack = 0;
        #1 rst_n = 1'b1;
        tick();
        total++; if (s_cyc !== 1'b1 || s_adr !== 30'h1010) begin bad++; $display("FAIL areset_regrant got cyc=%b adr=%h want 1 1010", s_cyc, s_adr); end
        m1_cyc = 0; m1_stb = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_init_lockout();
        test_round_robin();
        test_read();
        test_timeout();
        test_ack_beats_timeout();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
